nx_ram_wr_arb: RTL and testbench
================================

NX_RAM_WR_ARB -- requirements
Module: nx_ram_wr_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 64, data/bit-enable width of the controlled 1AR1W RAM write port.
REQ-002 SHALL have parameter DEPTH, default 256, number of RAM entries; address width is ceil(log2(DEPTH)).
REQ-003 SHALL have parameter INIT_VALUE, default 0 (WIDTH bits), value written to every entry during a sweep.
REQ-004 clk  input  1  single clock for all state.
REQ-005 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-006 init_start  input  1  one-cycle pulse requesting a re-initialisation sweep.
REQ-007 init_busy  output  1  high while the sweep state machine is in SWEEP.
REQ-008 req0_valid / req1_valid  input  1  write request valid, requester 0/1.
REQ-009 req0_ready / req1_ready  output  1  request accepted this cycle, combinational from state and both valids.
REQ-010 req0_addr / req1_addr  input  log2(DEPTH)  write address.
REQ-011 req0_data / req1_data  input  WIDTH  write data.
REQ-012 req0_bwe / req1_bwe  input  WIDTH  per-bit write enable, 1 = write bit.
REQ-013 mem_web  output  1  RAM write enable, active-low, registered.
REQ-014 mem_wa  output  log2(DEPTH)  RAM write address, registered.
REQ-015 mem_din  output  WIDTH  RAM write data, registered.
REQ-016 mem_bwe  output  WIDTH  RAM bit write enable, registered.

Function
REQ-017 State machine SHALL have states SWEEP and RUN; SWEEP entered on reset and on init_start sampled high in RUN; init_start during SWEEP SHALL be ignored.
REQ-018 Entering SWEEP SHALL clear sweep counter to 0; each SWEEP cycle SHALL register web=0, wa=counter, din=INIT_VALUE, bwe=all ones, then increment counter.
REQ-019 When counter equals DEPTH-1 in SWEEP the next state SHALL be RUN; a sweep SHALL last exactly DEPTH cycles.
REQ-020 In SWEEP both ready outputs SHALL be 0.
REQ-021 In RUN, exactly one valid requester SHALL receive ready=1; with none valid both ready=0.
REQ-022 When both are valid in RUN, grant SHALL go to the requester not granted most recently (round-robin); last-grant pointer updates only on an accepted transfer.
REQ-023 A transfer accepted at edge N SHALL appear on mem_* after edge N (one-cycle latency), with mem_web=0 for exactly that cycle.
REQ-024 In RUN with no accept, mem_web SHALL register 1; mem_wa/mem_din/mem_bwe SHALL hold previous values.
REQ-025 init_start high in the same cycle as an accepted request SHALL complete that write first; sweep writes begin the following cycle.
REQ-026 Back-to-back accepts SHALL be supported at one write per cycle, no bubbles.

Reset
REQ-027 On rst_n low: state=SWEEP, counter=0, last-grant pointer=requester 1 (so requester 0 wins the first conflict), mem_web=1, mem_wa=0, mem_din=0, mem_bwe=0, init_busy=1, both ready=0.
REQ-028 rst_n asserted mid-sweep or mid-RUN SHALL abort immediately; the sweep SHALL restart at address 0 after release.

Configuration
REQ-029 Macro NX_RAM_WR_ARB_STATS_EN defined: SHALL add output stat_conflict (16 bits), counting RUN cycles with both valids high, reset 0, saturating at 16'hFFFF, cleared on entry to SWEEP.
REQ-030 Macro NX_RAM_WR_ARB_STATS_EN undefined: port stat_conflict and its counter SHALL not exist; all other behaviour identical.

Verification (DEPTH=16, WIDTH=8, INIT_VALUE=8'hA5)
REQ-031 Release reset -> mem_web=0 for 16 consecutive cycles, wa 0..15, din=A5, bwe=FF; init_busy falls after the 16th sweep cycle; ready=0 throughout.
REQ-032 RUN, req0 valid addr=3 data=11 bwe=0F -> req0_ready=1 same cycle; next cycle mem_web=0, wa=3, din=11, bwe=0F; following cycle mem_web=1.
REQ-033 RUN, both valid continuously for 4 cycles -> grants 0,1,0,1; stat_conflict=4 with NX_RAM_WR_ARB_STATS_EN.
REQ-034 init_start pulse coinciding with req1 accept addr=7 -> write to 7 issued, then 16-cycle sweep, readys 0, requests held pending.
REQ-035 rst_n pulsed low at sweep address 9 -> mem_web=1 during reset; after release sweep restarts at wa=0 and runs 16 cycles.

Source files
------------

// File: rtl/nx_ram_wr_arb.sv
// Two-requester round-robin write arbiter for a 1AR1W RAM, with a power-up/on-demand
// initialisation sweep. Optional conflict counter enabled by NX_RAM_WR_ARB_STATS_EN.
module nx_ram_wr_arb #(
    parameter int              WIDTH      = 64,
    parameter int              DEPTH      = 256,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0,
    localparam int             AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef NX_RAM_WR_ARB_STATS_EN
    output logic [15:0]      stat_conflict,
`endif
    input  logic             init_start,
    output logic             init_busy,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [AW-1:0]    req0_addr,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [WIDTH-1:0] req0_bwe,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [AW-1:0]    req1_addr,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [WIDTH-1:0] req1_bwe,

    output logic             mem_web,
    output logic [AW-1:0]    mem_wa,
    output logic [WIDTH-1:0] mem_din,
    output logic [WIDTH-1:0] mem_bwe
);

    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t           state_reg;
    logic [AW-1:0]    cnt_reg;
    logic             last_grant_reg;   // 1: requester 1 won the most recent transfer
    logic             mem_web_reg;
    logic [AW-1:0]    mem_wa_reg;
    logic [WIDTH-1:0] mem_din_reg;
    logic [WIDTH-1:0] mem_bwe_reg;

    logic             grant0;
    logic             grant1;
    logic             accept;
    logic [AW-1:0]    sel_addr;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] sel_bwe;

    // Grant is a pure function of state and valids so ready is available in the same cycle.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_reg == ST_RUN) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant_reg;
                grant1 = !last_grant_reg;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign accept   = grant0 | grant1;
    assign sel_addr = grant1 ? req1_addr : req0_addr;
    assign sel_data = grant1 ? req1_data : req0_data;
    assign sel_bwe  = grant1 ? req1_bwe  : req0_bwe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_SWEEP;
            cnt_reg        <= '0;
            last_grant_reg <= 1'b1;
            mem_web_reg    <= 1'b1;
            mem_wa_reg     <= '0;
            mem_din_reg    <= '0;
            mem_bwe_reg    <= '0;
        end else begin
            case (state_reg)
                ST_SWEEP: begin
                    mem_web_reg <= 1'b0;
                    mem_wa_reg  <= cnt_reg;
                    mem_din_reg <= INIT_VALUE;
                    mem_bwe_reg <= '1;
                    if (cnt_reg == LAST_ADDR) begin
                        state_reg <= ST_RUN;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        mem_web_reg    <= 1'b0;
                        mem_wa_reg     <= sel_addr;
                        mem_din_reg    <= sel_data;
                        mem_bwe_reg    <= sel_bwe;
                        last_grant_reg <= grant1;
                    end else begin
                        mem_web_reg <= 1'b1;
                    end
                    // A write accepted alongside init_start still goes out; the sweep follows it.
                    if (init_start) begin
                        state_reg <= ST_SWEEP;
                        cnt_reg   <= '0;
                    end
                end
                default: begin
                    state_reg <= ST_SWEEP;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

`ifdef NX_RAM_WR_ARB_STATS_EN
    logic [15:0] stat_conflict_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_conflict_reg <= '0;
        end else if (state_reg == ST_RUN) begin
            if (init_start) begin
                stat_conflict_reg <= '0;
            end else if (req0_valid && req1_valid && (stat_conflict_reg != 16'hFFFF)) begin
                stat_conflict_reg <= stat_conflict_reg + 16'd1;
            end
        end
    end

    assign stat_conflict = stat_conflict_reg;
`endif

    assign init_busy  = (state_reg == ST_SWEEP);
    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign mem_web    = mem_web_reg;
    assign mem_wa     = mem_wa_reg;
    assign mem_din    = mem_din_reg;
    assign mem_bwe    = mem_bwe_reg;

endmodule

// File: tb/tb_nx_ram_wr_arb.sv
// Directed bench for nx_ram_wr_arb (DEPTH=16, WIDTH=8, INIT_VALUE=A5) with a transaction-level
// reference model compared every cycle, plus literal expectations at key points.
module tb_nx_ram_wr_arb;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam logic [WIDTH-1:0] INIT = 8'hA5;

    logic             clk;
    logic             rst_n;
    logic             init_start;
    logic             init_busy;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [AW-1:0]    req0_addr, req1_addr;
    logic [WIDTH-1:0] req0_data, req1_data;
    logic [WIDTH-1:0] req0_bwe, req1_bwe;
    logic             mem_web;
    logic [AW-1:0]    mem_wa;
    logic [WIDTH-1:0] mem_din;
    logic [WIDTH-1:0] mem_bwe;
`ifdef NX_RAM_WR_ARB_STATS_EN
    logic [15:0]      stat_conflict;
`endif

    int checks = 0;
    int errors = 0;

    nx_ram_wr_arb #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .INIT_VALUE(INIT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef NX_RAM_WR_ARB_STATS_EN
        .stat_conflict(stat_conflict),
`endif
        .init_start(init_start),
        .init_busy(init_busy),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_addr(req0_addr),
        .req0_data(req0_data),
        .req0_bwe(req0_bwe),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_addr(req1_addr),
        .req1_data(req1_data),
        .req1_bwe(req1_bwe),
        .mem_web(mem_web),
        .mem_wa(mem_wa),
        .mem_din(mem_din),
        .mem_bwe(mem_bwe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Round-robin rule: -1 none, 0 or 1 the winner; on conflict the one not granted last wins.
    function automatic int pick(input logic v0, input logic v1, input int prev);
        if (v0 && v1) return (prev == 0) ? 1 : 0;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    // Reference model: sweep is "cycles remaining", run mode emits the picked request.
    bit               m_busy;
    int               m_left;
    int               m_prev;
    int               m_conf;
    logic             e_web;
    logic [AW-1:0]    e_wa;
    logic [WIDTH-1:0] e_din;
    logic [WIDTH-1:0] e_bwe;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b1;
            m_left <= DEPTH;
            m_prev <= 1;
            m_conf <= 0;
            e_web  <= 1'b1;
            e_wa   <= '0;
            e_din  <= '0;
            e_bwe  <= '0;
        end else if (m_busy) begin
            e_web  <= 1'b0;
            e_wa   <= AW'(DEPTH - m_left);
            e_din  <= INIT;
            e_bwe  <= 8'hFF;
            m_left <= m_left - 1;
            if (m_left == 1) m_busy <= 1'b0;
        end else begin
            case (pick(req0_valid, req1_valid, m_prev))
                0: begin
                    e_web <= 1'b0; e_wa <= req0_addr; e_din <= req0_data; e_bwe <= req0_bwe;
                    m_prev <= 0;
                end
                1: begin
                    e_web <= 1'b0; e_wa <= req1_addr; e_din <= req1_data; e_bwe <= req1_bwe;
                    m_prev <= 1;
                end
                default: e_web <= 1'b1;
            endcase
            if (req0_valid && req1_valid && m_conf != 65535) m_conf <= m_conf + 1;
            if (init_start) begin
                m_busy <= 1'b1;
                m_left <= DEPTH;
                m_conf <= 0;
            end
        end
    end

    always @(negedge clk) begin
        int w;
        w = m_busy ? -1 : pick(req0_valid, req1_valid, m_prev);
        chk("cyc_req0_ready", req0_ready, (w == 0));
        chk("cyc_req1_ready", req1_ready, (w == 1));
        chk("cyc_init_busy", init_busy, m_busy);
        chk("cyc_mem_web", mem_web, e_web);
        chk("cyc_mem_wa", mem_wa, e_wa);
        chk("cyc_mem_din", mem_din, e_din);
        chk("cyc_mem_bwe", mem_bwe, e_bwe);
`ifdef NX_RAM_WR_ARB_STATS_EN
        chk("cyc_stat_conflict", stat_conflict, m_conf);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; init_start = 1'b0;
        req0_valid = 1'b0; req0_addr = 4'd1; req0_data = 8'h10; req0_bwe = 8'hFF;
        req1_valid = 1'b0; req1_addr = 4'd2; req1_data = 8'h20; req1_bwe = 8'h3C;
        repeat (3) tick();
        chk("rst_web", mem_web, 1); chk("rst_wa", mem_wa, 0);
        chk("rst_bwe", mem_bwe, 0); chk("rst_busy", init_busy, 1);
        $display("reset held: web=%0b busy=%0b", mem_web, init_busy);

        // Power-up sweep, both requesters waiting throughout.
        rst_n = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1 chk("sweep_r0_blocked", req0_ready, 0); chk("sweep_r1_blocked", req1_ready, 0);
        tick();
        chk("sw0_web", mem_web, 0); chk("sw0_wa", mem_wa, 0);
        chk("sw0_din", mem_din, 8'hA5); chk("sw0_bwe", mem_bwe, 8'hFF);
        for (int i = 1; i < 15; i++) begin
            tick();
            chk("sw_wa", mem_wa, i);
            $display("sweep write wa=%0d din=%0h", mem_wa, mem_din);
        end
        tick();
        chk("sw15_wa", mem_wa, 15); chk("sw15_web", mem_web, 0); chk("sw_done_busy", init_busy, 0);

        // Four conflict cycles: grants 0,1,0,1.
        for (int i = 0; i < 4; i++) begin
            chk("conf_r0", req0_ready, (i % 2 == 0)); chk("conf_r1", req1_ready, (i % 2 == 1));
            tick();
            chk("conf_wa", mem_wa, (i % 2 == 0) ? 1 : 2);
            $display("conflict grant=%0d wa=%0d din=%0h", i % 2, mem_wa, mem_din);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
`ifdef NX_RAM_WR_ARB_STATS_EN
        chk("stat_conflict_4", stat_conflict, 4);
`endif

        // Single write from requester 0.
        req0_valid = 1'b1; req0_addr = 4'd3; req0_data = 8'h11; req0_bwe = 8'h0F;
        #1 chk("single_r0_ready", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        chk("single_web", mem_web, 0); chk("single_wa", mem_wa, 3);
        chk("single_din", mem_din, 8'h11); chk("single_bwe", mem_bwe, 8'h0F);
        tick();
        chk("single_idle_web", mem_web, 1); chk("single_hold_wa", mem_wa, 3);
        $display("single write done wa=%0d web=%0b", mem_wa, mem_web);

        // Back-to-back writes from requester 1.
        req1_valid = 1'b1;
        for (int i = 4; i < 7; i++) begin
            req1_addr = AW'(i); req1_data = 8'(8'h40 + i); req1_bwe = 8'hC3;
            tick();
            chk("b2b_web", mem_web, 0); chk("b2b_wa", mem_wa, i);
            $display("b2b write wa=%0d din=%0h", mem_wa, mem_din);
        end
        req1_valid = 1'b0;

        // init_start together with an accepted write: write first, then sweep; request held.
        req1_valid = 1'b1; req1_addr = 4'd7; req1_data = 8'h77; req1_bwe = 8'hF0; init_start = 1'b1;
        #1 chk("init_r1_ready", req1_ready, 1);
        tick();
        init_start = 1'b0;
        chk("init_wr_wa", mem_wa, 7); chk("init_wr_din", mem_din, 8'h77);
        chk("init_wr_web", mem_web, 0); chk("init_busy_set", init_busy, 1);
        for (int i = 0; i < 16; i++) begin
            chk("resweep_r1_blocked", req1_ready, 0);
            tick();
            init_start = (i == 5);
            chk("resweep_wa", mem_wa, i); chk("resweep_din", mem_din, 8'hA5);
        end
        init_start = 1'b0;
        chk("resweep_done_busy", init_busy, 0); chk("pending_r1_ready", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        chk("pending_wa", mem_wa, 7); chk("pending_din", mem_din, 8'h77);
        $display("pending write issued wa=%0d", mem_wa);

        // Reset in the middle of a sweep.
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        repeat (10) tick();
        chk("mid_sweep_wa9", mem_wa, 9);
        rst_n = 1'b0;
        #1;
        chk("midrst_web", mem_web, 1); chk("midrst_wa", mem_wa, 0); chk("midrst_busy", init_busy, 1);
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("rst_sweep_wa", mem_wa, i); chk("rst_sweep_web", mem_web, 0);
        end
        chk("rst_sweep_done", init_busy, 0);
        $display("sweep after reset complete busy=%0b", init_busy);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
